img_cap: RTL and testbench
==========================

Name: img_cap

Overview:
- Video-stream sink: the receiving end of the vs/de/data raster interface driven by the image generator.
- Frames the stream on vs and checks line and frame geometry against parameters.
- Packs 8-bit pixels into 32-bit words and presents them on a valid/ready write port with a word address, for the downstream frame-buffer writer and for simulation dump/compare.

Parameters:
- ACTIVE_IW, 640, active pixels per line; must be a multiple of 4.
- ACTIVE_IH, 480, active lines per frame.
- FIFO_DEPTH, 8, output FIFO depth in 32-bit words; power of 2, at least 4.
- AW, $clog2(ACTIVE_IW*ACTIVE_IH/4), width of the word address.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- vs  in  1  frame envelope; 0->1 edge marks frame start
- de  in  1  pixel valid; one high run per line
- data  in  8  pixel, valid when de=1
- m_valid  out  1  output word valid
- m_ready  in  1  downstream accept
- m_data  out  32  packed word; first pixel of the group in [7:0]
- m_addr  out  AW  word index within frame, from 0
- m_last  out  1  word index = ACTIVE_IW*ACTIVE_IH/4-1
- frame_done  out  1  one-cycle pulse at frame end
- err_flags  out  4  sticky per frame: [0] line length, [1] short frame, [2] extra line, [3] FIFO overflow
- frame_cnt  out  16  completed frames, wraps at 65535->0

Behaviour:
- Reset values: all outputs 0. Internal vs_d resets to 1, so a frame already in progress at reset release is skipped. FIFO empty, state WAIT_VS.
- Inputs are sampled on posedge clk; vs_d and de_d are one-cycle delayed copies.
- States:
  - WAIT_VS: de is ignored. On vs & !vs_d: clear err_flags, line_cnt, pix_cnt and word address; go to CAPTURE.
  - CAPTURE: on each de=1 cycle, shift data into the packer and increment pix_cnt.
    - On every 4th pixel, write {data, 3 held pixels} to the FIFO on that same edge, tagged with addr and last.
    - Line end is de_d & !de:
      - If pix_cnt != ACTIVE_IW, set err[0].
      - If 1-3 pixels are pending, flush them as a zero-padded word.
      - Reset pix_cnt and the packer; increment line_cnt.
      - When line_cnt reaches ACTIVE_IH, pulse frame_done, increment frame_cnt, go to DRAIN.
  - DRAIN: any de rising edge sets err[2]; its pixels are discarded. On !vs go to WAIT_VS.
- vs falls in CAPTURE before ACTIVE_IH lines: set err[1], pulse frame_done, increment frame_cnt, go to WAIT_VS. A partial line pending at that point is flushed as above without a line-length check.
- vs rises again while in CAPTURE: treat as short frame (err[1], frame_done) and restart capture in the same cycle. err_flags then clears and err[1] is lost; the bench checks the frame_done pulse only.
- frame_done and the err_flags clear may fall in the same cycle; the pre-clear flags are visible during the frame_done cycle.
- FIFO:
  - First-word-fall-through. A word written on edge E shows m_valid=1 from edge E, i.e. one-cycle latency from the 4th pixel sample.
  - Pop when m_valid & m_ready. Simultaneous push and pop when full is allowed: no overflow, occupancy unchanged.
  - Push when full without a pop: the word is dropped, err[3] is set, and the address still advances, so downstream sees an address gap.
- m_addr increments per pushed word. Words and addresses are never reordered.
- Asynchronous reset mid-frame: FIFO contents are discarded, nothing is flushed, and capture resumes at the next true frame start.

Decomposition:
- img_cap_pkg:
  - state enum (WAIT_VS, CAPTURE, DRAIN)
  - error bit index constants
  - PIX_PER_WORD=4
- Sub-module img_cap_fifo: synchronous FWFT FIFO with parameters WIDTH (32+AW+1) and DEPTH. Ports: push, full, pop, empty, dout. Overflow detection lives in img_cap.

Test Plan (benches use ACTIVE_IW=8, ACTIVE_IH=4, FIFO_DEPTH=4, m_ready=1 unless stated):
- Nominal frame, pixel value = index 0..31 -> 8 words; word0=0x03020100, word7=0x1F1E1D1C; addr 0..7; m_last only on addr 7; frame_done once after line 4; err_flags=0; frame_cnt=1.
- Line 2 carries 6 pixels -> err[0]=1; that line yields a full word plus a zero-padded word 0x0000xxxx; frame still completes.
- vs drops after 2 lines -> err[1]=1; frame_done pulses; 4 words out; next frame starts with err_flags=0.
- m_ready=0 for a whole frame -> first 4 words held; err[3]=1; after m_ready=1, addr 0..3 is delivered.
- Fifth de line after line 4 with vs still high -> err[2]=1; no extra words; frame_cnt unchanged.
- Reset asserted mid-line 1 with vs high at release -> no output until the next vs 0->1; that frame is captured cleanly.

Source files
------------

// File: rtl/img_cap_pkg.sv
// Shared types and constants for the img_cap video-stream sink.
package img_cap_pkg;

  typedef enum logic [1:0] {
    StWaitVs,
    StCapture,
    StDrain
  } state_e;

  localparam int unsigned ErrLineLen    = 0;
  localparam int unsigned ErrShortFrame = 1;
  localparam int unsigned ErrExtraLine  = 2;
  localparam int unsigned ErrOverflow   = 3;

  localparam int unsigned PIX_PER_WORD = 4;

endpackage

// File: rtl/img_cap_fifo.sv
// Synchronous first-word-fall-through FIFO; dout is valid whenever empty is low.
module img_cap_fifo #(
  parameter int unsigned WIDTH = 36,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full  = (cnt_q == CntW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign dout  = mem_q[rptr_q];

  // A push while full is accepted only if a pop frees the slot on the same edge.
  always_comb begin
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
    wptr_d  = wptr_q + PtrW'(do_push);
    rptr_d  = rptr_q + PtrW'(do_pop);
    cnt_d   = cnt_q + CntW'(do_push) - CntW'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din;
  end

endmodule

// File: rtl/img_cap.sv
// Video-stream sink: frames vs/de/data, checks geometry and packs pixels into
// addressed 32-bit words on a valid/ready port.
module img_cap
  import img_cap_pkg::*;
#(
  parameter int unsigned ACTIVE_IW  = 640,
  parameter int unsigned ACTIVE_IH  = 480,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned AW         = $clog2(ACTIVE_IW * ACTIVE_IH / 4)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          vs,
  input  logic          de,
  input  logic [7:0]    data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [31:0]   m_data,
  output logic [AW-1:0] m_addr,
  output logic          m_last,
  output logic          frame_done,
  output logic [3:0]    err_flags,
  output logic [15:0]   frame_cnt
);

  localparam int unsigned Words = ACTIVE_IW * ACTIVE_IH / PIX_PER_WORD;
  localparam int unsigned PixW  = 16;
  localparam int unsigned LineW = $clog2(ACTIVE_IH + 1);
  localparam int unsigned FifoW = 32 + AW + 1;

  state_e           state_q, state_d;
  logic             vs_q, de_q;
  logic [PixW-1:0]  pix_cnt_q, pix_cnt_d;
  logic [LineW-1:0] line_cnt_q, line_cnt_d;
  logic [23:0]      pack_q, pack_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [3:0]       err_q, err_d;
  logic             frame_done_q, frame_done_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;

  logic             word_push, fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic             frame_start, line_end, pending;
  logic [31:0]      word_data;
  logic [FifoW-1:0] fifo_dout;

  // pix_cnt != 0 rejects a de fall left over from a line seen before capture began.
  assign line_end = de_q & ~de & (pix_cnt_q != '0);
  assign pending  = (pix_cnt_q[1:0] != 2'd0);
  assign fifo_pop = ~fifo_empty & m_ready;

  always_comb begin
    state_d      = state_q;
    pix_cnt_d    = pix_cnt_q;
    line_cnt_d   = line_cnt_q;
    pack_d       = pack_q;
    addr_d       = addr_q;
    err_d        = err_q;
    frame_done_d = 1'b0;
    frame_cnt_d  = frame_cnt_q;
    frame_start  = 1'b0;
    word_push    = 1'b0;
    word_data    = '0;

    unique case (state_q)
      StWaitVs: begin
        if (vs && !vs_q) begin
          frame_start = 1'b1;
          state_d     = StCapture;
        end
      end
      StCapture: begin
        if (vs && !vs_q) begin
          // New frame before this one finished: close it and restart at once.
          frame_done_d = 1'b1;
          frame_cnt_d  = frame_cnt_q + 16'd1;
          frame_start  = 1'b1;
        end else if (!vs) begin
          if (pending) begin
            word_push = 1'b1;
            word_data = {8'h00, pack_q};
          end
          if (!(line_end && line_cnt_q == LineW'(ACTIVE_IH - 1))) begin
            err_d[ErrShortFrame] = 1'b1;
          end
          frame_done_d = 1'b1;
          frame_cnt_d  = frame_cnt_q + 16'd1;
          pix_cnt_d    = '0;
          pack_d       = '0;
          state_d      = StWaitVs;
        end else if (de) begin
          unique case (pix_cnt_q[1:0])
            2'd0: pack_d[7:0]   = data;
            2'd1: pack_d[15:8]  = data;
            2'd2: pack_d[23:16] = data;
            default: begin
              word_push = 1'b1;
              word_data = {data, pack_q};
              pack_d    = '0;
            end
          endcase
          pix_cnt_d = (pix_cnt_q == '1) ? pix_cnt_q : pix_cnt_q + 1'b1;
        end else if (line_end) begin
          if (pix_cnt_q != PixW'(ACTIVE_IW)) err_d[ErrLineLen] = 1'b1;
          if (pending) begin
            word_push = 1'b1;
            word_data = {8'h00, pack_q};
          end
          pix_cnt_d  = '0;
          pack_d     = '0;
          line_cnt_d = line_cnt_q + 1'b1;
          if (line_cnt_q == LineW'(ACTIVE_IH - 1)) begin
            frame_done_d = 1'b1;
            frame_cnt_d  = frame_cnt_q + 16'd1;
            state_d      = StDrain;
          end
        end
      end
      StDrain: begin
        if (de && !de_q) err_d[ErrExtraLine] = 1'b1;
        if (!vs) state_d = StWaitVs;
      end
      default: state_d = StWaitVs;
    endcase

    if (frame_start) begin
      err_d      = '0;
      line_cnt_d = '0;
      pix_cnt_d  = '0;
      pack_d     = '0;
      addr_d     = '0;
    end else if (word_push) begin
      // Dropped words still consume an address so the loss is visible downstream.
      addr_d = addr_q + 1'b1;
    end

    fifo_push = word_push & (~fifo_full | fifo_pop);
    if (word_push && fifo_full && !fifo_pop) err_d[ErrOverflow] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StWaitVs;
      vs_q         <= 1'b1;
      de_q         <= 1'b0;
      pix_cnt_q    <= '0;
      line_cnt_q   <= '0;
      pack_q       <= '0;
      addr_q       <= '0;
      err_q        <= '0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      vs_q         <= vs;
      de_q         <= de;
      pix_cnt_q    <= pix_cnt_d;
      line_cnt_q   <= line_cnt_d;
      pack_q       <= pack_d;
      addr_q       <= addr_d;
      err_q        <= err_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  img_cap_fifo #(
    .WIDTH(FifoW),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (fifo_push),
    .din  ({word_data, addr_q, addr_q == AW'(Words - 1)}),
    .full (fifo_full),
    .pop  (fifo_pop),
    .empty(fifo_empty),
    .dout (fifo_dout)
  );

  assign m_valid    = ~fifo_empty;
  assign m_data     = m_valid ? fifo_dout[FifoW-1 -: 32] : '0;
  assign m_addr     = m_valid ? fifo_dout[AW:1] : '0;
  assign m_last     = m_valid & fifo_dout[0];
  assign frame_done = frame_done_q;
  assign err_flags  = err_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_img_cap.sv
// Scoreboard bench for img_cap on an 8x4 raster with a 4-word output FIFO.
module tb_img_cap;

  localparam int unsigned IW = 8;
  localparam int unsigned IH = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW = 3;
  localparam int LastAddr = IW * IH / 4 - 1;

  localparam logic [31:0] NOM [8] = '{
    32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C,
    32'h13121110, 32'h17161514, 32'h1B1A1918, 32'h1F1E1D1C
  };

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          vs = 1'b0;
  logic          de = 1'b0;
  logic [7:0]    data = '0;
  logic          m_ready = 1'b1;
  logic          m_valid;
  logic [31:0]   m_data;
  logic [AW-1:0] m_addr;
  logic          m_last;
  logic          frame_done;
  logic [3:0]    err_flags;
  logic [15:0]   frame_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  logic [35:0] exp_q [$];  // {data, addr, last}
  logic [19:0] fd_q [$];   // {err_flags, frame_cnt}
  logic [35:0] mon_w;
  logic [19:0] mon_f;

  img_cap #(
    .ACTIVE_IW (IW),
    .ACTIVE_IH (IH),
    .FIFO_DEPTH(DEPTH),
    .AW        (AW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .vs        (vs),
    .de        (de),
    .data      (data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_addr    (m_addr),
    .m_last    (m_last),
    .frame_done(frame_done),
    .err_flags (err_flags),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_word: got addr %0d data 0x%08h, expected no word",
                   m_addr, m_data);
        end else begin
          mon_w = exp_q.pop_front();
          check("word_data", 64'(m_data), 64'(mon_w[35:4]));
          check("word_addr", 64'(m_addr), 64'(mon_w[3:1]));
          check("word_last", 64'(m_last), 64'(mon_w[0]));
        end
      end
      if (frame_done) begin
        if (fd_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_frame_done: got pulse at frame_cnt %0d, expected none",
                   frame_cnt);
        end else begin
          mon_f = fd_q.pop_front();
          check("done_err_flags", 64'(err_flags), 64'(mon_f[19:16]));
          check("done_frame_cnt", 64'(frame_cnt), 64'(mon_f[15:0]));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_word(input logic [31:0] d, input int a);
    logic [AW-1:0] aw;
    aw = AW'(a);
    exp_q.push_back({d, aw, a == LastAddr});
  endtask

  task automatic push_nom(input int lo, input int hi);
    for (int k = lo; k <= hi; k++) push_word(NOM[k], k);
  endtask

  task automatic start_frame(input logic [3:0] err, input logic [15:0] cnt, input bit exp_done);
    if (exp_done) fd_q.push_back({err, cnt});
    vs = 1'b1;
    tick(2);
  endtask

  task automatic end_frame();
    vs = 1'b0;
    tick(3);
  endtask

  task automatic send_line(input int line, input int npix);
    for (int i = 0; i < npix; i++) begin
      de   = 1'b1;
      data = 8'(line * 8 + i);
      tick(1);
    end
    de = 1'b0;
    tick(3);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_m_valid"}, 64'(m_valid), 64'd0);
    check({tag, "_m_data"}, 64'(m_data), 64'd0);
    check({tag, "_m_addr"}, 64'(m_addr), 64'd0);
    check({tag, "_m_last"}, 64'(m_last), 64'd0);
    check({tag, "_frame_done"}, 64'(frame_done), 64'd0);
    check({tag, "_err_flags"}, 64'(err_flags), 64'd0);
    check({tag, "_frame_cnt"}, 64'(frame_cnt), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1);
  end

  initial begin
    tick(2);
    reset_checks("reset");
    rst_n = 1'b1;
    tick(2);

    // Nominal frame.
    push_nom(0, 7);
    start_frame(4'b0000, 16'd1, 1'b1);
    for (int l = 0; l < 4; l++) send_line(l, 8);
    end_frame();

    // Line 2 short by two pixels: full word plus zero-padded word.
    push_nom(0, 1);
    push_word(32'h0B0A0908, 2);
    push_word(32'h00000D0C, 3);
    push_nom(4, 7);
    start_frame(4'b0001, 16'd2, 1'b1);
    send_line(0, 8);
    send_line(1, 6);
    send_line(2, 8);
    send_line(3, 8);
    end_frame();

    // vs drops after two lines.
    push_nom(0, 3);
    start_frame(4'b0010, 16'd3, 1'b1);
    send_line(0, 8);
    send_line(1, 8);
    end_frame();
    check("short_frame_err_held", 64'(err_flags), 64'h2);

    // Following frame starts clean.
    push_nom(0, 7);
    start_frame(4'b0000, 16'd4, 1'b1);
    check("err_cleared_at_start", 64'(err_flags), 64'h0);
    for (int l = 0; l < 4; l++) send_line(l, 8);
    end_frame();

    // Downstream stalled for a whole frame: first four words held, rest dropped.
    m_ready = 1'b0;
    push_nom(0, 3);
    start_frame(4'b1000, 16'd5, 1'b1);
    for (int l = 0; l < 4; l++) send_line(l, 8);
    end_frame();
    check("held_valid", 64'(m_valid), 64'd1);
    check("held_head_addr", 64'(m_addr), 64'd0);
    m_ready = 1'b1;
    tick(8);

    // Extra line after the last one while vs stays high.
    push_nom(0, 7);
    start_frame(4'b0000, 16'd6, 1'b1);
    for (int l = 0; l < 4; l++) send_line(l, 8);
    send_line(4, 8);
    check("extra_line_err", 64'(err_flags), 64'h4);
    check("extra_line_frame_cnt", 64'(frame_cnt), 64'd6);
    end_frame();

    // Reset in the middle of line 1 with vs high at release.
    start_frame(4'b0000, 16'd0, 1'b0);
    de = 1'b1;
    data = 8'h00;
    tick(1);
    data = 8'h01;
    tick(1);
    rst_n = 1'b0;
    data = 8'h02;
    tick(2);
    reset_checks("midreset");
    rst_n = 1'b1;
    for (int i = 3; i < 8; i++) begin
      data = 8'(i);
      tick(1);
    end
    de = 1'b0;
    tick(3);
    for (int l = 1; l < 4; l++) send_line(l, 8);
    end_frame();
    check("skipped_frame_cnt", 64'(frame_cnt), 64'd0);
    check("skipped_no_word", 64'(m_valid), 64'd0);

    push_nom(0, 7);
    start_frame(4'b0000, 16'd1, 1'b1);
    for (int l = 0; l < 4; l++) send_line(l, 8);
    end_frame();

    for (int i = 0; i < 100 && (exp_q.size() != 0 || fd_q.size() != 0); i++) tick(1);
    check("words_outstanding", 64'(exp_q.size()), 64'd0);
    check("frame_done_outstanding", 64'(fd_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
